// File: rtl/riscv_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_hazard_ctrl_pkg
//  Description : Opcodes, special instruction words, FSM states and forward
//                select encodings shared by the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_hazard_ctrl_pkg;

    localparam logic [6:0]  c_opc_lw    = 7'b0000011;
    localparam logic [6:0]  c_opc_sw    = 7'b0100011;
    localparam logic [6:0]  c_opc_b     = 7'b1100011;
    localparam logic [6:0]  c_opc_op    = 7'b0110011;
    localparam logic [6:0]  c_opc_addi  = 7'b0010011;
    localparam logic [6:0]  c_f7_mul    = 7'b0000001;
    localparam logic [31:0] c_word_eof  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_word_nop  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic wen;
        logic is_load;
        logic is_mul;
        logic uses_rs1;
        logic uses_rs2;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] opcode, input logic [6:0] funct7);
        dec_t d;
        d = '0;
        case (opcode)
            c_opc_lw:   begin d.wen = 1'b1; d.is_load = 1'b1; d.uses_rs1 = 1'b1; end
            c_opc_sw:   begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            c_opc_b:    begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            c_opc_op:   begin
                d.wen      = 1'b1;
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.is_mul   = (funct7 == c_f7_mul);
            end
            c_opc_addi: begin d.wen = 1'b1; d.uses_rs1 = 1'b1; end
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_hazard_ctrl_if
//  Description : Core-to-hazard-controller signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             ex_br_taken;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mul_busy;
    logic             done;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] clock_count;

    modport master (
        output id_valid, id_instr, ex_br_taken,
        input  issue, stall, flush, fwd_a, fwd_b, mul_busy, done,
               instr_count, clock_count
    );

    modport slave (
        input  id_valid, id_instr, ex_br_taken,
        output issue, stall, flush, fwd_a, fwd_b, mul_busy, done,
               instr_count, clock_count
    );
endinterface
`default_nettype wire

// File: rtl/riscv_hazard_ctrl_slot.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_hazard_ctrl_slot
//  Description : One shadow pipeline slot of destination/source info with
//                hold, load and bubble behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_hazard_ctrl_slot #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_wen,
    input  logic              i_is_load,
    input  logic              i_is_mul,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_wen,
    output logic              o_is_load,
    output logic              o_is_mul,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2
);
    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic              r_wen;
    logic              r_is_load;
    logic              r_is_mul;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;

    // A bubble clears every field so stale register numbers can never match.
    always_ff @(posedge clk) begin
        if (rst || (!i_hold && !i_load)) begin
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_is_load <= 1'b0;
            r_is_mul  <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
        end else if (!i_hold) begin
            r_valid   <= i_valid;
            r_rd      <= i_rd;
            r_wen     <= i_wen;
            r_is_load <= i_is_load;
            r_is_mul  <= i_is_mul;
            r_rs1     <= i_rs1;
            r_rs2     <= i_rs2;
        end
    end

    assign o_valid   = r_valid;
    assign o_rd      = r_rd;
    assign o_wen     = r_wen;
    assign o_is_load = r_is_load;
    assign o_is_mul  = r_is_mul;
    assign o_rs1     = r_rs1;
    assign o_rs2     = r_rs2;
endmodule
`default_nettype wire

// File: rtl/riscv_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_hazard_ctrl
//  Description : Stall/flush/forwarding controller with MUL interlock,
//                end-of-program drain FSM and run counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    riscv_hazard_ctrl_if.slave bus
);
    import riscv_hazard_ctrl_pkg::*;

    localparam logic [3:0] c_mul_init = 4'(MUL_LAT - 1);

    dec_t              w_dec;
    logic              w_id_eof;
    logic              w_id_real;
    logic              w_id_wen;
    logic [REG_AW-1:0] w_id_rd;
    logic [REG_AW-1:0] w_id_rs1;
    logic [REG_AW-1:0] w_id_rs2;
    logic              w_mul_busy;
    logic              w_load_use;
    logic              w_stall;
    logic              w_flush;
    logic              w_issue;
    logic              w_mem_fwd_ok;
    logic              w_wb_fwd_ok;
    logic              w_pipe_empty;

    logic              w_ex_valid,  w_mem_valid,  w_wb_valid;
    logic [REG_AW-1:0] w_ex_rd,     w_mem_rd,     w_wb_rd;
    logic              w_ex_wen,    w_mem_wen,    w_wb_wen;
    logic              w_ex_isld,   w_mem_isld,   w_wb_isld;
    logic              w_ex_ismul,  w_mem_ismul,  w_wb_ismul;
    logic [REG_AW-1:0] w_ex_rs1,    w_mem_rs1,    w_wb_rs1;
    logic [REG_AW-1:0] w_ex_rs2,    w_mem_rs2,    w_wb_rs2;
    logic              w_unused_fields;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_mul_cnt;
    logic [CNT_W-1:0]  r_instr_count;
    logic [CNT_W-1:0]  r_clock_count;

    function automatic fwd_e fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_rd
    );
        fwd_e f;
        f = FWD_RF;
        if (mem_ok && (rs == mem_rd))
            f = FWD_MEM;
        else if (wb_ok && (rs == wb_rd))
            f = FWD_WB;
        return f;
    endfunction

    // Source fields of non-readers are zeroed; x0 writers are not writers.
    assign w_dec     = decode(bus.id_instr[6:0], bus.id_instr[31:25]);
    assign w_id_eof  = (bus.id_instr == c_word_eof);
    assign w_id_real = bus.id_valid && !w_id_eof && (bus.id_instr != c_word_nop);
    assign w_id_rd   = bus.id_instr[7 +: REG_AW];
    assign w_id_wen  = w_dec.wen && (w_id_rd != '0);
    assign w_id_rs1  = w_dec.uses_rs1 ? bus.id_instr[15 +: REG_AW] : '0;
    assign w_id_rs2  = w_dec.uses_rs2 ? bus.id_instr[20 +: REG_AW] : '0;

    assign w_mul_busy = (r_mul_cnt != 4'd0);
    assign w_load_use = w_id_real && w_ex_valid && w_ex_isld && w_ex_wen &&
                        ((w_id_rs1 == w_ex_rd) || (w_id_rs2 == w_ex_rd));
    assign w_flush    = bus.ex_br_taken;
    assign w_stall    = w_load_use || w_mul_busy || (r_state != ST_RUN);
    assign w_issue    = w_id_real && !w_stall && !w_flush && (r_state == ST_RUN);

    assign w_mem_fwd_ok = w_mem_valid && w_mem_wen && !w_mem_isld;
    assign w_wb_fwd_ok  = w_wb_valid && w_wb_wen;
    assign w_pipe_empty = !w_ex_valid && !w_mem_valid && !w_wb_valid && !w_mul_busy;

    riscv_hazard_ctrl_slot #(.REG_AW(REG_AW)) u_slot_ex (
        .clk(CLOCK_50), .rst(rst), .i_hold(w_mul_busy), .i_load(w_issue),
        .i_valid(1'b1), .i_rd(w_id_rd), .i_wen(w_id_wen), .i_is_load(w_dec.is_load),
        .i_is_mul(w_dec.is_mul), .i_rs1(w_id_rs1), .i_rs2(w_id_rs2),
        .o_valid(w_ex_valid), .o_rd(w_ex_rd), .o_wen(w_ex_wen), .o_is_load(w_ex_isld),
        .o_is_mul(w_ex_ismul), .o_rs1(w_ex_rs1), .o_rs2(w_ex_rs2)
    );

    riscv_hazard_ctrl_slot #(.REG_AW(REG_AW)) u_slot_mem (
        .clk(CLOCK_50), .rst(rst), .i_hold(1'b0), .i_load(!w_mul_busy),
        .i_valid(w_ex_valid), .i_rd(w_ex_rd), .i_wen(w_ex_wen), .i_is_load(w_ex_isld),
        .i_is_mul(w_ex_ismul), .i_rs1(w_ex_rs1), .i_rs2(w_ex_rs2),
        .o_valid(w_mem_valid), .o_rd(w_mem_rd), .o_wen(w_mem_wen), .o_is_load(w_mem_isld),
        .o_is_mul(w_mem_ismul), .o_rs1(w_mem_rs1), .o_rs2(w_mem_rs2)
    );

    riscv_hazard_ctrl_slot #(.REG_AW(REG_AW)) u_slot_wb (
        .clk(CLOCK_50), .rst(rst), .i_hold(1'b0), .i_load(1'b1),
        .i_valid(w_mem_valid), .i_rd(w_mem_rd), .i_wen(w_mem_wen), .i_is_load(w_mem_isld),
        .i_is_mul(w_mem_ismul), .i_rs1(w_mem_rs1), .i_rs2(w_mem_rs2),
        .o_valid(w_wb_valid), .o_rd(w_wb_rd), .o_wen(w_wb_wen), .o_is_load(w_wb_isld),
        .o_is_mul(w_wb_ismul), .o_rs1(w_wb_rs1), .o_rs2(w_wb_rs2)
    );

    assign w_unused_fields = ^{w_ex_ismul, w_mem_ismul, w_wb_ismul, w_wb_isld,
                               w_mem_rs1, w_mem_rs2, w_wb_rs1, w_wb_rs2};

    always_ff @(posedge CLOCK_50) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // A flushed EOF never reaches the RUN exit, so the program keeps running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (bus.id_valid && w_id_eof && !w_flush && !w_stall)
                          w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pipe_empty)
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst)
            r_mul_cnt <= 4'd0;
        else if (w_mul_busy)
            r_mul_cnt <= r_mul_cnt - 4'd1;
        else if (w_issue && w_dec.is_mul)
            r_mul_cnt <= c_mul_init;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_instr_count <= '0;
            r_clock_count <= '0;
        end else begin
            if (w_issue)
                r_instr_count <= r_instr_count + CNT_W'(1);
            if (r_state != ST_DONE)
                r_clock_count <= r_clock_count + CNT_W'(1);
        end
    end

    assign bus.issue       = w_issue;
    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.fwd_a       = fwd_pick(w_ex_rs1, w_mem_fwd_ok, w_mem_rd, w_wb_fwd_ok, w_wb_rd);
    assign bus.fwd_b       = fwd_pick(w_ex_rs2, w_mem_fwd_ok, w_mem_rd, w_wb_fwd_ok, w_wb_rd);
    assign bus.mul_busy    = w_mul_busy;
    assign bus.done        = (r_state == ST_DONE);
    assign bus.instr_count = r_instr_count;
    assign bus.clock_count = r_clock_count;
endmodule
`default_nettype wire

// File: tb/tb_riscv_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_hazard_ctrl
//  Description : Cycle-table bench for riscv_hazard_ctrl (MUL_LAT 3 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_hazard_ctrl;

    localparam logic [31:0] c_eof = 32'hFFFF_FFFF;

    typedef struct {
        bit          rst;
        bit          valid;
        logic [31:0] instr;
        bit          br;
        bit          iss;
        bit          stl;
        bit          fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          busy;
        bit          dn;
        int          icnt;
        int          ccnt;
        bit          l1;
    } vec_t;

    logic        CLOCK_50 = 1'b0;
    logic        rst      = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        ex_br    = 1'b0;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   nb3      = 0;
    int   nb1      = 0;
    bit   seen_idle = 1'b0;
    vec_t vecs[$];

    riscv_hazard_ctrl_if #(.CNT_W(32)) bus3 ();
    riscv_hazard_ctrl_if #(.CNT_W(32)) bus1 ();

    assign bus3.id_valid    = id_valid;
    assign bus3.id_instr    = id_instr;
    assign bus3.ex_br_taken = ex_br;
    assign bus1.id_valid    = id_valid;
    assign bus1.id_instr    = id_instr;
    assign bus1.ex_br_taken = ex_br;

    riscv_hazard_ctrl #(.REG_AW(5), .MUL_LAT(3), .CNT_W(32)) u_dut3 (
        .CLOCK_50(CLOCK_50), .rst(rst), .bus(bus3)
    );
    riscv_hazard_ctrl #(.REG_AW(5), .MUL_LAT(1), .CNT_W(32)) u_dut1 (
        .CLOCK_50(CLOCK_50), .rst(rst), .bus(bus1)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_beq(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
    endfunction

    task automatic add_rst();
        vec_t v;
        v = '{rst: 1'b1, valid: 1'b0, instr: 32'd0, br: 1'b0, iss: 1'b0, stl: 1'b0, fl: 1'b0,
              fa: 2'b00, fb: 2'b00, busy: 1'b0, dn: 1'b0, icnt: 0, ccnt: -1, l1: 1'b0};
        vecs.push_back(v);
    endtask

    task automatic add(input bit valid, input logic [31:0] instr, input bit br,
                       input bit iss, input bit stl, input bit fl,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input bit busy, input bit dn, input int icnt, input int ccnt, input bit l1);
        vec_t v;
        v = '{rst: 1'b0, valid: valid, instr: instr, br: br, iss: iss, stl: stl, fl: fl,
              fa: fa, fb: fb, busy: busy, dn: dn, icnt: icnt, ccnt: ccnt, l1: l1};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU chain and x0 destination
        add_rst();
        add(1, enc_addi(1, 0, 5),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 0);
        add(1, enc_r(7'd0, 2, 1, 1),    0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, enc_r(7'd0, 0, 1, 1),    0, 1, 0, 0, 2'b01, 2'b01, 0, 0, 2, -1, 0);
        add(1, enc_r(7'd0, 8, 0, 0),    0, 1, 0, 0, 2'b10, 2'b10, 0, 0, 3, -1, 0);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4, -1, 0);
        // load-use on rs1 then rs2
        add_rst();
        add(1, enc_lw(3, 0),            0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, -1, 0);
        add(1, enc_r(7'd0, 4, 3, 0),    0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, enc_r(7'd0, 4, 3, 0),    0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, enc_lw(3, 0),            0, 1, 0, 0, 2'b10, 2'b00, 0, 0, 2, -1, 0);
        add(1, enc_r(7'd0, 4, 0, 3),    0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3, -1, 0);
        add(1, enc_r(7'd0, 4, 0, 3),    0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3, -1, 0);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 4, -1, 0);
        // multi-cycle MUL followed by dependent ADDI
        add_rst();
        add(1, enc_r(7'd1, 5, 1, 2),    0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, -1, 1);
        add(1, enc_addi(6, 5, 1),       0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, -1, 1);
        add(1, enc_addi(6, 5, 1),       0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1, -1, 1);
        add(1, enc_addi(6, 5, 1),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 1);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2, -1, 1);
        // taken branch kills lw x7 in ID
        add_rst();
        add(1, enc_beq(1, 2),           0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, -1, 0);
        add(1, enc_lw(7, 0),            1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, enc_r(7'd0, 9, 7, 7),    0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, -1, 0);
        // branch during a load-use stall
        add_rst();
        add(1, enc_lw(3, 0),            0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, -1, 0);
        add(1, enc_r(7'd0, 4, 3, 0),    1, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        // three instructions then EOF: drain and done
        add_rst();
        add(1, enc_addi(1, 0, 1),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 0);
        add(1, enc_addi(2, 0, 2),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, enc_addi(3, 0, 3),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2, -1, 0);
        add(1, c_eof,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3,  3, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 3, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 3,  7, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 3,  7, 0);
        // reset out of DONE, reset mid-DRAIN, rerun
        add_rst();
        add(1, enc_addi(1, 0, 1),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 0);
        add(1, c_eof,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add_rst();
        add(0, 32'd0,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0,  0, 0);
        add(1, enc_addi(1, 0, 1),       0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0,  1, 0);
        add(1, c_eof,                   0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, -1, 0);
        add(1, c_eof,                   0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1,  6, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLOCK_50); #1;
            rst      = vecs[i].rst;
            id_valid = vecs[i].valid;
            id_instr = vecs[i].instr;
            ex_br    = vecs[i].br;
            @(negedge CLOCK_50);
            if (!vecs[i].rst) begin
                check($sformatf("row%0d issue", i),    32'(bus3.issue),    32'(vecs[i].iss));
                check($sformatf("row%0d stall", i),    32'(bus3.stall),    32'(vecs[i].stl));
                check($sformatf("row%0d flush", i),    32'(bus3.flush),    32'(vecs[i].fl));
                check($sformatf("row%0d fwd_a", i),    32'(bus3.fwd_a),    32'(vecs[i].fa));
                check($sformatf("row%0d fwd_b", i),    32'(bus3.fwd_b),    32'(vecs[i].fb));
                check($sformatf("row%0d mul_busy", i), 32'(bus3.mul_busy), 32'(vecs[i].busy));
                check($sformatf("row%0d done", i),     32'(bus3.done),     32'(vecs[i].dn));
                check($sformatf("row%0d instr_count", i), bus3.instr_count, 32'(vecs[i].icnt));
                if (vecs[i].ccnt >= 0)
                    check($sformatf("row%0d clock_count", i), bus3.clock_count, 32'(vecs[i].ccnt));
                if (vecs[i].l1) begin
                    check($sformatf("row%0d lat1 mul_busy", i), 32'(bus1.mul_busy), 32'd0);
                    check($sformatf("row%0d lat1 stall", i),    32'(bus1.stall),    32'd0);
                end
            end
        end

        // DONE is sticky: counters frozen, nothing issues
        for (int k = 0; k < 4; k++) begin
            @(posedge CLOCK_50); #1;
            id_valid = 1'b1;
            id_instr = enc_addi(2, 0, 7);
            @(negedge CLOCK_50);
            check($sformatf("done_hold%0d done", k),  32'(bus3.done),  32'd1);
            check($sformatf("done_hold%0d issue", k), 32'(bus3.issue), 32'd0);
            check($sformatf("done_hold%0d clock_count", k), bus3.clock_count, 32'd6);
            check($sformatf("done_hold%0d instr_count", k), bus3.instr_count, 32'd1);
        end

        // MUL busy window length, bounded wait
        @(posedge CLOCK_50); #1;
        rst = 1'b1; id_valid = 1'b0;
        @(posedge CLOCK_50); #1;
        rst = 1'b0; id_valid = 1'b1; id_instr = enc_r(7'd1, 5, 1, 2);
        @(negedge CLOCK_50);
        check("mul_seq issue", 32'(bus3.issue), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLOCK_50); #1;
            id_valid = 1'b0;
            @(negedge CLOCK_50);
            if (bus3.mul_busy) nb3++;
            if (bus1.mul_busy) nb1++;
            if (!bus3.mul_busy) begin
                seen_idle = 1'b1;
                break;
            end
        end
        check("mul_seq drop_in_time", 32'(seen_idle), 32'd1);
        check("mul_seq lat3 busy_cycles", 32'(nb3), 32'd2);
        check("mul_seq lat1 busy_cycles", 32'(nb1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
